// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsa_pkg
// Description : Shared opcode, state and phase encodings for the RSA
//               exponentiation sequencer and its Montgomery operation timer.
// Revision    : 1.0 - initial release
// ============================================================================
package rsa_pkg;

    typedef enum logic [2:0] {
        OP_IDLE     = 3'd0,
        OP_TOMONT   = 3'd1,
        OP_INIT     = 3'd2,
        OP_SQR      = 3'd3,
        OP_MUL      = 3'd4,
        OP_FROMMONT = 3'd5
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TOMONT   = 3'd1,
        ST_INIT     = 3'd2,
        ST_SQR      = 3'd3,
        ST_MUL      = 3'd4,
        ST_FROMMONT = 3'd5,
        ST_DONE     = 3'd6
    } top_state_t;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_CLR   = 3'd1,
        PH_LOAD  = 3'd2,
        PH_RUN   = 3'd3,
        PH_STORE = 3'd4,
        PH_WB    = 3'd5
    } mmm_phase_t;

    // Clear, load, WIDTH iterations, store, write-back.
    function automatic int cycles_per_op(input int width);
        return width + 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmm_op_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmm_op_timer
// Description : Per-operation Montgomery multiplier pin sequencer
//               (CLR, LOAD, RUN x WIDTH, STORE, WB) with write-back pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module mmm_op_timer
    import rsa_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic abort,
    input  logic go,
    input  logic wr_x_en,
    input  logic wr_bm_en,
    output logic mmm_en,
    output logic mmm_rst,
    output logic mmm_ld_a,
    output logic mmm_ld_r,
    output logic mmm_lock,
    output logic wb_x,
    output logic wb_bm,
    output logic op_done
);

    localparam int            C_CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_CW-1:0] C_CNT_TOP = C_CW'(WIDTH - 1);

    mmm_phase_t      r_phase;
    logic [C_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_phase  <= PH_IDLE;
            r_cnt    <= '0;
            mmm_en   <= 1'b0;
            mmm_rst  <= 1'b1;
            mmm_ld_a <= 1'b0;
            mmm_ld_r <= 1'b0;
            mmm_lock <= 1'b1;
            wb_x     <= 1'b0;
            wb_bm    <= 1'b0;
            op_done  <= 1'b0;
        end else begin
            // Idle pin levels unless the next phase overrides them.
            mmm_en   <= 1'b0;
            mmm_rst  <= 1'b1;
            mmm_ld_a <= 1'b0;
            mmm_ld_r <= 1'b0;
            mmm_lock <= 1'b1;
            wb_x     <= 1'b0;
            wb_bm    <= 1'b0;
            op_done  <= 1'b0;
            if (abort) begin
                r_phase <= PH_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_phase)
                    PH_IDLE, PH_WB: begin
                        if (go) begin
                            r_phase <= PH_CLR;
                            mmm_rst <= 1'b0;
                        end else begin
                            r_phase <= PH_IDLE;
                        end
                    end
                    PH_CLR: begin
                        r_phase  <= PH_LOAD;
                        mmm_ld_a <= 1'b1;
                        mmm_en   <= 1'b1;
                        mmm_lock <= 1'b0;
                    end
                    PH_LOAD: begin
                        r_phase  <= PH_RUN;
                        r_cnt    <= C_CNT_TOP;
                        mmm_en   <= 1'b1;
                        mmm_lock <= 1'b0;
                    end
                    PH_RUN: begin
                        mmm_en   <= 1'b1;
                        mmm_lock <= 1'b0;
                        if (r_cnt == '0) begin
                            r_phase  <= PH_STORE;
                            mmm_ld_r <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    PH_STORE: begin
                        r_phase <= PH_WB;
                        wb_x    <= wr_x_en;
                        wb_bm   <= wr_bm_en;
                        op_done <= 1'b1;
                    end
                    default: r_phase <= PH_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/modexp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : modexp_sequencer
// Description : Left-to-right constant-time square-and-multiply sequencer
//               driving the Montgomery multiplier and operand steering.
// Revision    : 1.0 - initial release
// ============================================================================
module modexp_sequencer
    import rsa_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int EXP_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 start,
    input  logic                 abort,
    input  logic [EXP_WIDTH-1:0] exp,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           op,
    output logic                 wr_x,
    output logic                 wr_bm,
    output logic                 mmm_en,
    output logic                 mmm_rst,
    output logic                 mmm_ld_a,
    output logic                 mmm_ld_r,
    output logic                 mmm_lock
);

    localparam int            C_BW       = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [C_BW-1:0] C_BIT_LAST = C_BW'(EXP_WIDTH - 1);

    top_state_t           r_state;
    op_t                  r_op;
    logic                 r_busy;
    logic                 r_done;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [C_BW-1:0]      r_bit;

    logic w_op_done;
    logic w_go;
    logic w_wr_x_en;
    logic w_wr_bm_en;

    // Next operation's CLR must coincide with the edge that ends the current WB.
    assign w_go = !abort && (((r_state == ST_IDLE) && start) ||
                             (w_op_done && (r_state != ST_FROMMONT)));

    // A zero exponent bit still runs MUL but drops its write-back.
    assign w_wr_x_en  = (r_op == OP_INIT) || (r_op == OP_SQR) || (r_op == OP_FROMMONT) ||
                        ((r_op == OP_MUL) && r_exp[EXP_WIDTH-1]);
    assign w_wr_bm_en = (r_op == OP_TOMONT);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= ST_IDLE;
            r_op    <= OP_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_exp   <= '0;
            r_bit   <= '0;
        end else if (abort && (r_state != ST_IDLE)) begin
            r_state <= ST_IDLE;
            r_op    <= OP_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_exp   <= '0;
            r_bit   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_state <= ST_TOMONT;
                        r_op    <= OP_TOMONT;
                        r_busy  <= 1'b1;
                        r_exp   <= exp;
                        r_bit   <= '0;
                    end
                end
                ST_TOMONT: if (w_op_done) begin
                    r_state <= ST_INIT;
                    r_op    <= OP_INIT;
                end
                ST_INIT: if (w_op_done) begin
                    r_state <= ST_SQR;
                    r_op    <= OP_SQR;
                end
                ST_SQR: if (w_op_done) begin
                    r_state <= ST_MUL;
                    r_op    <= OP_MUL;
                end
                ST_MUL: if (w_op_done) begin
                    r_exp <= r_exp << 1;
                    if (r_bit == C_BIT_LAST) begin
                        r_state <= ST_FROMMONT;
                        r_op    <= OP_FROMMONT;
                    end else begin
                        r_bit   <= r_bit + 1'b1;
                        r_state <= ST_SQR;
                        r_op    <= OP_SQR;
                    end
                end
                ST_FROMMONT: if (w_op_done) begin
                    r_state <= ST_DONE;
                    r_op    <= OP_IDLE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_op    <= OP_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    mmm_op_timer #(
        .WIDTH(WIDTH)
    ) u_timer (
        .clk      (clk),
        .rstb     (rstb),
        .abort    (abort),
        .go       (w_go),
        .wr_x_en  (w_wr_x_en),
        .wr_bm_en (w_wr_bm_en),
        .mmm_en   (mmm_en),
        .mmm_rst  (mmm_rst),
        .mmm_ld_a (mmm_ld_a),
        .mmm_ld_r (mmm_ld_r),
        .mmm_lock (mmm_lock),
        .wb_x     (wr_x),
        .wb_bm    (wr_bm),
        .op_done  (w_op_done)
    );

    assign busy = r_busy;
    assign done = r_done;
    assign op   = r_op;

endmodule
`default_nettype wire

// File: tb/tb_modexp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_modexp_sequencer
// Description : Scoreboard bench for modexp_sequencer with a modular
//               arithmetic model of the datapath (M=13, R=16).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_modexp_sequencer;
    import rsa_pkg::*;

    localparam int C_W      = 4;
    localparam int C_EW     = 4;
    localparam int C_CPO    = 8;
    localparam int C_DONE   = 89;
    localparam int C_MOD    = 13;
    localparam int C_RINV   = 9;
    localparam int C_R2     = 9;
    localparam int C_BASE   = 3;
    localparam int C_IDLE_V = 12'h009;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] exp_in = 4'h0;
    logic       busy, done, wr_x, wr_bm;
    logic [2:0] op;
    logic       mmm_en, mmm_rst, mmm_ld_a, mmm_ld_r, mmm_lock;

    modexp_sequencer #(.WIDTH(C_W), .EXP_WIDTH(C_EW)) dut (
        .clk(clk), .rstb(rstb), .start(start), .abort(abort), .exp(exp_in),
        .busy(busy), .done(done), .op(op), .wr_x(wr_x), .wr_bm(wr_bm),
        .mmm_en(mmm_en), .mmm_rst(mmm_rst), .mmm_ld_a(mmm_ld_a),
        .mmm_ld_r(mmm_ld_r), .mmm_lock(mmm_lock)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_acc = 0;
    int busy_cnt = 0;
    int wrx_cnt = 0;
    int xm = 0;
    int bm_m = 0;
    int m_rel, m_act, m_req;
    int q_op[$];
    int q_evt[$];
    int q_x[$];
    int q_pin[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic int mont(input int a, input int b);
        return (a * b * C_RINV) % C_MOD;
    endfunction

    function automatic int outvec();
        return int'({busy, done, op, wr_x, wr_bm, mmm_en, mmm_rst, mmm_ld_a, mmm_ld_r, mmm_lock});
    endfunction

    // Expected op sequence, write pulses, done and first-op pin timing, up to cycle lim.
    task automatic push_run(input logic [3:0] e, input int xexp, input int lim);
        int ops[11];
        int pins[8];
        int kind;
        ops[0] = 1; ops[1] = 2; ops[10] = 5;
        for (int i = 0; i < 4; i++) begin
            ops[2 + 2*i] = 3;
            ops[3 + 2*i] = 4;
        end
        pins[0] = 5'b00001; pins[1] = 5'b11100; pins[2] = 5'b10100; pins[3] = 5'b10100;
        pins[4] = 5'b10100; pins[5] = 5'b10100; pins[6] = 5'b10110; pins[7] = 5'b10001;
        for (int c = 0; c < 8; c++)
            if (c + 1 <= lim) q_pin.push_back((c + 1) * 64 + pins[c]);
        for (int i = 0; i < 11; i++) begin
            if (1 + C_CPO*i <= lim) q_op.push_back((1 + C_CPO*i) * 8 + ops[i]);
            if (ops[i] == 1)      kind = 2;
            else if (ops[i] == 4) kind = e[3 - (i - 3)/2] ? 1 : 0;
            else                  kind = 1;
            if (kind != 0 && C_CPO*(i + 1) <= lim) q_evt.push_back(C_CPO*(i + 1) * 8 + kind);
        end
        if (C_DONE <= lim) begin
            q_evt.push_back(C_DONE * 8 + 4);
            q_x.push_back(xexp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rstb) begin
            m_rel = cyc - t_acc;
            if (busy) busy_cnt++;
            if (wr_x) wrx_cnt++;
            if (q_pin.size() > 0 && q_pin[0] / 64 == m_rel) begin
                m_req = q_pin.pop_front();
                check("pins", int'({mmm_rst, mmm_ld_a, mmm_en, mmm_ld_r, mmm_lock}), m_req % 64);
            end
            if (!mmm_rst) begin
                m_act = m_rel * 8 + int'(op);
                if (q_op.size() == 0) check("op_unexpected", m_act, -1);
                else                  check("op_seq", m_act, q_op.pop_front());
            end
            if (wr_x || wr_bm || done) begin
                m_act = m_rel * 8 + int'(wr_x) + 2 * int'(wr_bm) + 4 * int'(done);
                if (q_evt.size() == 0) check("evt_unexpected", m_act, -1);
                else                   check("evt", m_act, q_evt.pop_front());
                if (done) begin
                    if (q_x.size() == 0) check("x_unexpected", xm, -1);
                    else                 check("x_at_done", xm, q_x.pop_front());
                end
                if (wr_bm) bm_m = mont(C_BASE, C_R2);
                if (wr_x) begin
                    case (op)
                        3'd2:    xm = mont(1, C_R2);
                        3'd3:    xm = mont(xm, xm);
                        3'd4:    xm = mont(xm, bm_m);
                        3'd5:    xm = mont(xm, 1);
                        default: xm = -1;
                    endcase
                end
            end
        end
    end

    task automatic run(input logic [3:0] e, input int xexp, input int nwr,
                       input int abort_at, input int rst_at, input bit stray);
        int lim;
        bit normal;
        normal = (abort_at == 0) && (rst_at == 0);
        lim = (abort_at > 0) ? abort_at : ((rst_at > 0) ? rst_at - 1 : 1000);
        xm = 0; bm_m = 0;
        push_run(e, xexp, lim);
        @(negedge clk);
        exp_in = e; start = 1'b1; t_acc = cyc;
        busy_cnt = 0; wrx_cnt = 0;
        for (int rel = 1; rel <= 93; rel++) begin
            @(negedge clk);
            start  = stray && (rel == 50 || rel == C_DONE);
            exp_in = ~e;
            if (rel == abort_at) abort = 1'b1;
            if (abort_at > 0 && rel == abort_at + 1) begin
                abort = 1'b0;
                check("abort_outs", outvec(), C_IDLE_V);
            end
            if (normal && rel == C_DONE + 1) check("busy_after_done", int'(busy), 0);
            if (rst_at > 0 && rel == rst_at - 1) begin
                @(posedge clk);
                #2 rstb = 1'b0;
                #1 check("rst_outs", outvec(), C_IDLE_V);
                @(negedge clk);
                #1 rstb = 1'b1;
                rel++;
            end
        end
        if (normal) check("busy_cycles", busy_cnt, C_DONE);
        check("wr_x_count", wrx_cnt, nwr);
        check("queues_drained", q_op.size() + q_evt.size() + q_pin.size() + q_x.size(), 0);
        check("idle_after", outvec(), C_IDLE_V);
        q_op.delete(); q_evt.delete(); q_pin.delete(); q_x.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs", outvec(), C_IDLE_V);
        rstb = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1 || i == 10 || i == 20) check("idle_outs", outvec(), C_IDLE_V);
        end
        abort = 1'b1; start = 1'b1; exp_in = 4'hB;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort_start_idle", outvec(), C_IDLE_V);

        run(4'hB, 9, 9, 0, 0, 1'b0);
        run(4'h0, 1, 6, 0, 0, 1'b0);
        run(4'hF, 1, 10, 0, 0, 1'b0);
        run(4'hB, 0, 4, 40, 0, 1'b0);
        run(4'h5, 9, 8, 0, 0, 1'b0);
        run(4'hB, 0, 3, 0, 40, 1'b0);
        run(4'h5, 9, 8, 0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/modexp_sequencer.md
Name: modexp_sequencer

Overview:
Control FSM that drives the control pins of the Montgomery multiplier (en, rst_mmm, ld_a, ld_r, lock) and runs left-to-right square-and-multiply modular exponentiation for the RSA core.
- Per Montgomery operation, it issues an opcode that tells the datapath which operands to steer to the multiplier's A/B inputs and which register receives R.
- It is the initiator for the multiplier; the multiplier only responds to these pins.

Parameters:
- WIDTH, 4, operand width of the multiplier; sets the number of iteration cycles per operation.
- EXP_WIDTH, 4, exponent width in bits.

Ports:
- clk  input  1  system clock.
- rstb  input  1  asynchronous active-low reset.
- start  input  1  begin exponentiation; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE without done.
- exp  input  EXP_WIDTH  exponent; captured on accepted start.
- busy  output  1  high from the cycle after start acceptance through the done cycle.
- done  output  1  one-cycle pulse when the result is in X.
- op  output  3  operand steering code, valid and stable for the whole operation.
- wr_x  output  1  one-cycle pulse: datapath loads X from R.
- wr_bm  output  1  one-cycle pulse: datapath loads Bm (Montgomery base) from R.
- mmm_en  output  1  multiplier enable.
- mmm_rst  output  1  multiplier soft clear, active low.
- mmm_ld_a  output  1  multiplier A shift-register load.
- mmm_ld_r  output  1  multiplier result load.
- mmm_lock  output  1  multiplier result hold.

Behaviour:
- Reset (async, rstb=0): state IDLE; busy=0, done=0, op=OP_IDLE, wr_x=0, wr_bm=0, mmm_en=0, mmm_rst=1, mmm_ld_a=0, mmm_ld_r=0, mmm_lock=1; counters and exponent register cleared.
- Top FSM: IDLE -> TOMONT -> INIT -> {SQR, MUL} x EXP_WIDTH -> FROMMONT -> DONE -> IDLE.
- Opcode and write-back per operation:
  - TOMONT: A=base, B=R2; writes Bm.
  - INIT: A=ONE, B=R2; writes X.
  - SQR: A=X, B=X; writes X.
  - MUL: A=X, B=Bm; writes X only if the current exponent bit is 1.
  - FROMMONT: A=X, B=ONE; writes X.
- Exponent scanning: bits are processed MSB first from the captured exp register.
- Constant time: MUL always runs. When the exponent bit is 0, wr_x is suppressed; this is a dummy multiply.
- Per-operation sub-FSM, WIDTH+4 cycles, op held constant throughout:
  - CLR (1 cycle): mmm_rst=0, lock=1.
  - LOAD (1 cycle): mmm_ld_a=1, mmm_en=1, lock=0.
  - RUN (WIDTH cycles): mmm_en=1; down-counter from WIDTH-1 to 0.
  - STORE (1 cycle): mmm_ld_r=1, mmm_en=1.
  - WB (1 cycle): mmm_lock=1, mmm_en=0; wr_x/wr_bm pulse per the table above.
- Outside LOAD/RUN/STORE: mmm_en=0 and mmm_lock=1.
- Latency:
  - Operation count is 2*EXP_WIDTH+3.
  - The first CLR occurs in the cycle after the start edge.
  - done is high in cycle (2*EXP_WIDTH+3)*(WIDTH+4)+1 after acceptance.
  - Defaults (WIDTH=4, EXP_WIDTH=4): 11 operations, done in cycle 89.
  - Latency is independent of exp.
- DONE state: done=1 for one cycle, busy=1; next state IDLE.
- start while busy: ignored. start and done in the same cycle: start ignored. start in IDLE: accepted the same edge.
- abort (any non-IDLE state): next cycle IDLE with reset output values; no done and no write pulse. abort has priority over WB.
- abort in IDLE: no effect. abort and start together in IDLE: abort wins; start is not accepted.
- rstb low mid-operation: immediate reset values; no done.
- exp=0: all MULs are dummies; the result is Montgomery one converted back, i.e. 1.

Decomposition:
- Shared package rsa_pkg:
  - op_t enum: OP_IDLE=0, OP_TOMONT=1, OP_INIT=2, OP_SQR=3, OP_MUL=4, OP_FROMMONT=5.
  - top-state enum.
  - mmm-phase enum (CLR, LOAD, RUN, STORE, WB).
  - localparam function for cycles per operation.
- Sub-module mmm_op_timer: runs the per-operation sub-FSM and iteration counter. It accepts go and write-enable inputs and returns the control pins, a wb pulse and op_done.
- The top FSM handles opcode sequencing, the exponent shift register, busy/done and abort.

Test Plan:
- Reset then idle, start=0 for 20 cycles -> all outputs at reset values; mmm_rst=1, mmm_lock=1.
- exp=4'b1011, start pulse -> op sequence 1,2,3,4,3,4,3,4,3,4,5.
  - wr_x pulses on MULs only for bits 1,0,1,1.
  - wr_bm exactly once.
  - done in cycle 89; busy high cycles 1-89.
- One operation, timing check -> mmm_rst=0 for exactly 1 cycle, ld_a 1 cycle, en high for 6 consecutive cycles, ld_r in the 6th en cycle, lock high in WB.
- exp=0 and exp=4'hF -> identical latency of 89 cycles; number of wr_x pulses 6 and 10 respectively.
- abort asserted in cycle 40; separately, rstb dropped in cycle 40 -> outputs at reset values by cycle 41 (immediately for rstb); no done; a fresh start afterwards completes in 89 cycles.
- Integrated with the multiplier and operand muxes, M=13, R2=9, base=3, exp=5 -> X=9 at done. A start pulse while busy changes nothing.
